// File: rtl/simplerisc_pkg.sv
// Shared definitions for the SimpleRisc execute stage: control-word bit
// positions, flag bit positions and the divider sequencing states.
package simplerisc_pkg;

  localparam int IDX_IS_ST        = 0;
  localparam int IDX_IS_LD        = 1;
  localparam int IDX_IS_BEQ       = 2;
  localparam int IDX_IS_BGT       = 3;
  localparam int IDX_IS_UBRANCH   = 4;
  localparam int IDX_IS_IMMEDIATE = 5;
  localparam int IDX_IS_WB        = 6;
  localparam int IDX_IS_ADD       = 7;
  localparam int IDX_IS_SUB       = 8;
  localparam int IDX_IS_CMP       = 9;
  localparam int IDX_IS_MUL       = 10;
  localparam int IDX_IS_DIV       = 11;
  localparam int IDX_IS_MOD       = 12;
  localparam int IDX_IS_LSL       = 13;
  localparam int IDX_IS_LSR       = 14;
  localparam int IDX_IS_ASR       = 15;
  localparam int IDX_IS_OR        = 16;
  localparam int IDX_IS_AND       = 17;
  localparam int IDX_IS_CALL      = 18;
  localparam int IDX_IS_RET       = 19;
  localparam int IDX_IS_NOT       = 20;
  localparam int IDX_IS_MOV       = 21;

  // flags_out is {GT, E}
  localparam int FLAG_E  = 0;
  localparam int FLAG_GT = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } div_state_e;

endpackage

// File: rtl/simplerisc_ex_stage_if.sv
// Upstream (OF/EX) and downstream (EX/MA) signal bundle of the execute stage.
// slave is the stage's view; master is the driver/observer view.
interface simplerisc_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   branchTarget;
  logic [XLEN-1:0]   A;
  logic [XLEN-1:0]   B;
  logic [XLEN-1:0]   op2;
  logic [31:0]       instruction;
  logic [CTRL_W-1:0] control;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   pc_out;
  logic [XLEN-1:0]   aluResult_out;
  logic [XLEN-1:0]   op2_out;
  logic [31:0]       instruction_out;
  logic [CTRL_W-1:0] control_out;
  logic [XLEN-1:0]   branch;
  logic              isBranchTaken;
  logic [1:0]        flags_out;
  logic              busy;

  modport slave (
    input  in_valid, pc, branchTarget, A, B, op2, instruction, control, out_ready,
    output in_ready, out_valid, pc_out, aluResult_out, op2_out, instruction_out,
           control_out, branch, isBranchTaken, flags_out, busy
  );

  modport master (
    output in_valid, pc, branchTarget, A, B, op2, instruction, control, out_ready,
    input  in_ready, out_valid, pc_out, aluResult_out, op2_out, instruction_out,
           control_out, branch, isBranchTaken, flags_out, busy
  );
endinterface

// File: rtl/simplerisc_iter_div.sv
// Signed restoring divider, one quotient bit per clock, XLEN iterations.
// done pulses in the cycle of the last iteration; result is valid from the next cycle.
module simplerisc_iter_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            is_mod,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, a_q;
  logic            q_neg_q, r_neg_q, by_zero_q, mod_q;
  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] quo_fix, rem_fix;

  // Work on magnitudes; signs are reapplied once the iterations are over.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      a_q       <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      by_zero_q <= 1'b0;
      mod_q     <= 1'b0;
    end else if (start) begin
      cnt_q     <= CW'(XLEN);
      rem_q     <= '0;
      quo_q     <= A[XLEN-1] ? -A : A;
      dvs_q     <= B[XLEN-1] ? -B : B;
      a_q       <= A;
      q_neg_q   <= A[XLEN-1] ^ B[XLEN-1];
      r_neg_q   <= A[XLEN-1];
      by_zero_q <= (B == '0);
      mod_q     <= is_mod;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      if (!diff[XLEN]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= shifted[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  assign done    = (cnt_q == CW'(1));
  assign quo_fix = q_neg_q ? -quo_q : quo_q;
  assign rem_fix = r_neg_q ? -rem_q : rem_q;
  assign result  = by_zero_q ? (mod_q ? a_q : '1) : (mod_q ? rem_fix : quo_fix);

endmodule

// File: rtl/simplerisc_ex_stage.sv
// SimpleRisc execute stage with EX/MA output register, flags and branch resolution.
// Define SIMPLERISC_DIV_EN to build the iterative multi-cycle divider for div/mod.
module simplerisc_ex_stage
  import simplerisc_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CTRL_W  = 32,
  parameter int PC_STEP = 4
) (
  input logic                  clk,
  input logic                  rst,
  simplerisc_ex_stage_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  logic [CTRL_W-1:0] c;
  logic [SHW-1:0]    sh;
  logic              accept, taken, start_div, div_write;
  logic [XLEN-1:0]   alu_res, div_result;

  logic              valid_q, taken_q;
  logic [1:0]        flags_q;
  logic [XLEN-1:0]   pc_q, alu_q, op2_q, branch_q;
  logic [31:0]       instr_q;
  logic [CTRL_W-1:0] ctrl_q;

  assign c      = bus.control;
  assign sh     = bus.B[SHW-1:0];
  assign accept = bus.in_valid & bus.in_ready;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    alu_res = '0;
    if (c[IDX_IS_ADD] | c[IDX_IS_LD] | c[IDX_IS_ST]) alu_res = bus.A + bus.B;
    else if (c[IDX_IS_SUB])  alu_res = bus.A - bus.B;
    else if (c[IDX_IS_MUL])  alu_res = bus.A * bus.B;
    else if (c[IDX_IS_LSL])  alu_res = bus.A << sh;
    else if (c[IDX_IS_LSR])  alu_res = bus.A >> sh;
    else if (c[IDX_IS_ASR])  alu_res = $signed(bus.A) >>> sh;
    else if (c[IDX_IS_OR])   alu_res = bus.A | bus.B;
    else if (c[IDX_IS_AND])  alu_res = bus.A & bus.B;
    else if (c[IDX_IS_NOT])  alu_res = ~bus.B;
    else if (c[IDX_IS_MOV])  alu_res = bus.B;
    else if (c[IDX_IS_CALL]) alu_res = bus.pc + XLEN'(PC_STEP);
  end

  // Uses the flags as they stood before this instruction updates them.
  assign taken = c[IDX_IS_UBRANCH] | c[IDX_IS_CALL] | c[IDX_IS_RET]
               | (c[IDX_IS_BEQ] & flags_q[FLAG_E])
               | (c[IDX_IS_BGT] & flags_q[FLAG_GT]);

`ifdef SIMPLERISC_DIV_EN
  div_state_e state_q, state_d;
  logic       div_done;

  assign start_div = accept & (c[IDX_IS_DIV] | c[IDX_IS_MOD]);

  simplerisc_iter_div #(.XLEN(XLEN)) u_div (
    .clk    (clk),
    .rst    (rst),
    .start  (start_div),
    .A      (bus.A),
    .B      (bus.B),
    .is_mod (c[IDX_IS_MOD]),
    .done   (div_done),
    .result (div_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_div) state_d = S_DIV;
      S_DIV:   if (div_done) state_d = S_DONE;
      S_DONE:  if (~valid_q | bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign div_write    = (state_q == S_DONE) & (~valid_q | bus.out_ready);
  assign bus.in_ready = (state_q == S_IDLE) & (~valid_q | bus.out_ready);
  assign bus.busy     = (state_q == S_DIV);
`else
  assign start_div    = 1'b0;
  assign div_write    = 1'b0;
  assign div_result   = '0;
  assign bus.in_ready = ~valid_q | bus.out_ready;
  assign bus.busy     = 1'b0;
`endif

  // A divide latches its pass-through fields on accept and fills in the result later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      taken_q  <= 1'b0;
      flags_q  <= 2'b00;
      pc_q     <= '0;
      alu_q    <= '0;
      op2_q    <= '0;
      branch_q <= '0;
      instr_q  <= '0;
      ctrl_q   <= '0;
    end else if (div_write) begin
      alu_q   <= div_result;
      valid_q <= 1'b1;
    end else if (accept) begin
      valid_q  <= ~start_div;
      taken_q  <= taken;
      pc_q     <= bus.pc;
      alu_q    <= alu_res;
      op2_q    <= bus.op2;
      branch_q <= c[IDX_IS_RET] ? bus.A : bus.branchTarget;
      instr_q  <= bus.instruction;
      ctrl_q   <= c;
      if (c[IDX_IS_CMP]) begin
        flags_q[FLAG_E]  <= (bus.A == bus.B);
        flags_q[FLAG_GT] <= ($signed(bus.A) > $signed(bus.B));
      end
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid       = valid_q;
  assign bus.isBranchTaken   = taken_q & valid_q;
  assign bus.flags_out       = flags_q;
  assign bus.pc_out          = pc_q;
  assign bus.aluResult_out   = alu_q;
  assign bus.op2_out         = op2_q;
  assign bus.branch          = branch_q;
  assign bus.instruction_out = instr_q;
  assign bus.control_out     = ctrl_q;

endmodule

// File: tb/tb_simplerisc_ex_stage.sv
// Directed self-checking bench for simplerisc_ex_stage (XLEN=32), covering the
// default build and, when SIMPLERISC_DIV_EN is defined, the iterative divider.
module tb_simplerisc_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  simplerisc_ex_stage_if #(.XLEN(32), .CTRL_W(32)) bus ();

  simplerisc_ex_stage #(.XLEN(32), .CTRL_W(32), .PC_STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cbit(input int idx);
    logic [31:0] one;
    one = 32'd1;
    return one << idx;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one instruction for one clock; assumes in_ready is high.
  task automatic issue(input logic [31:0] ctrl, input logic [31:0] pc_v, input logic [31:0] bt,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] op2_v);
    bus.control      = ctrl;
    bus.pc           = pc_v;
    bus.branchTarget = bt;
    bus.A            = a;
    bus.B            = b;
    bus.op2          = op2_v;
    bus.instruction  = {8'hA5, pc_v[23:0]};
    bus.in_valid     = 1'b1;
    @(posedge clk); #1;
    bus.in_valid     = 1'b0;
  endtask

  task automatic alu_case(input string tag, input int idx, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    issue(cbit(idx), 32'h0, 32'h0, a, b, 32'h0);
    check(tag, 64'(bus.aluResult_out), 64'(exp));
  endtask

`ifdef SIMPLERISC_DIV_EN
  task automatic do_div(input string tag, input int idx, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n, nbusy, nready;
    issue(cbit(idx), 32'h0, 32'h0, a, b, 32'h0);
    n = 0; nbusy = 0; nready = 0;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      if (bus.busy === 1'b1) nbusy++;
      if (bus.in_ready === 1'b1) nready++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd33);
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'd32);
    check({tag, "_ready_cycles"}, 64'(nready), 64'd0);
    check({tag, "_result"}, 64'(bus.aluResult_out), 64'(exp));
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.pc = '0; bus.branchTarget = '0; bus.A = '0; bus.B = '0;
    bus.op2 = '0; bus.instruction = '0; bus.control = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_flags", 64'(bus.flags_out), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_alu", 64'(bus.aluResult_out), 64'd0);
    check("rst_taken", 64'(bus.isBranchTaken), 64'd0);

    // call
    issue(cbit(18), 32'h40, 32'h100, 32'h0, 32'h0, 32'h0);
    check("call_valid", 64'(bus.out_valid), 64'd1);
    check("call_branch", 64'(bus.branch), 64'h100);
    check("call_taken", 64'(bus.isBranchTaken), 64'd1);
    check("call_alu", 64'(bus.aluResult_out), 64'h44);
    check("call_pc_out", 64'(bus.pc_out), 64'h40);
    check("call_instr_out", 64'(bus.instruction_out), 64'hA500_0040);
    check("call_ctrl_out", 64'(bus.control_out), 64'(cbit(18)));

    // Idle cycle with out_ready high drains the register
    @(posedge clk); #1;
    check("drain_valid", 64'(bus.out_valid), 64'd0);
    check("drain_taken_qualified", 64'(bus.isBranchTaken), 64'd0);

    // ret
    issue(cbit(19), 32'h80, 32'h200, 32'd50, 32'h0, 32'h0);
    check("ret_branch", 64'(bus.branch), 64'd50);
    check("ret_taken", 64'(bus.isBranchTaken), 64'd1);

    // cmp 5,3 then bgt, beq
    issue(cbit(9), 32'h0, 32'h0, 32'd5, 32'd3, 32'h0);
    check("cmp_gt_flags", 64'(bus.flags_out), 64'b10);
    check("cmp_alu", 64'(bus.aluResult_out), 64'd0);
    check("cmp_taken", 64'(bus.isBranchTaken), 64'd0);
    issue(cbit(3), 32'h0, 32'h300, 32'h0, 32'h0, 32'h0);
    check("bgt_taken", 64'(bus.isBranchTaken), 64'd1);
    check("bgt_branch", 64'(bus.branch), 64'h300);
    issue(cbit(2), 32'h0, 32'h300, 32'h0, 32'h0, 32'h0);
    check("beq_not_taken", 64'(bus.isBranchTaken), 64'd0);
    check("flags_held", 64'(bus.flags_out), 64'b10);

    // cmp equal, then beq taken; signed compare -1 vs 1
    issue(cbit(9), 32'h0, 32'h0, 32'd7, 32'd7, 32'h0);
    check("cmp_eq_flags", 64'(bus.flags_out), 64'b01);
    issue(cbit(2), 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    check("beq_taken", 64'(bus.isBranchTaken), 64'd1);
    issue(cbit(9), 32'h0, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0);
    check("cmp_signed_flags", 64'(bus.flags_out), 64'b00);
    issue(cbit(4), 32'h0, 32'h500, 32'h0, 32'h0, 32'h0);
    check("ubranch_taken", 64'(bus.isBranchTaken), 64'd1);

    // ALU operations
    issue(cbit(0), 32'h0, 32'h0, 32'h1000, 32'd8, 32'hDEAD);
    check("st_alu", 64'(bus.aluResult_out), 64'h1008);
    check("st_op2_out", 64'(bus.op2_out), 64'hDEAD);
    alu_case("add_wrap", 7, 32'hFFFF_FFFF, 32'd1, 32'h0);
    alu_case("ld", 1, 32'h200, 32'h4, 32'h204);
    alu_case("sub", 8, 32'd3, 32'd5, 32'hFFFF_FFFE);
    alu_case("mul", 10, 32'd7, 32'd6, 32'd42);
    alu_case("mul_low", 10, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000);
    alu_case("lsl_mask", 13, 32'd1, 32'd33, 32'd2);
    alu_case("lsr", 14, 32'h8000_0000, 32'd4, 32'h0800_0000);
    alu_case("asr", 15, 32'h8000_0000, 32'd4, 32'hF800_0000);
    alu_case("or", 16, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
    alu_case("and", 17, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
    alu_case("not", 20, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF);
    alu_case("mov", 21, 32'h1234_5678, 32'hCAFE_BABE, 32'hCAFE_BABE);

    // Backpressure
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    issue(cbit(7), 32'h0, 32'h0, 32'd1, 32'd1, 32'h0);
    check("bp_valid", 64'(bus.out_valid), 64'd1);
    check("bp_alu", 64'(bus.aluResult_out), 64'd2);
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    bus.control = cbit(7); bus.A = 32'd10; bus.B = 32'd20; bus.in_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("bp_hold_alu", 64'(bus.aluResult_out), 64'd2);
    check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
    check("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_next_alu", 64'(bus.aluResult_out), 64'd30);
    check("bp_next_valid", 64'(bus.out_valid), 64'd1);

`ifdef SIMPLERISC_DIV_EN
    do_div("div_neg", 11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    do_div("mod_neg", 12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    do_div("div_zero", 11, 32'd9, 32'd0, 32'hFFFF_FFFF);
    do_div("mod_zero", 12, 32'd9, 32'd0, 32'd9);
    do_div("div_min", 11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    do_div("mod_min", 12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    do_div("div_pos", 11, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
`else
    issue(cbit(11), 32'h0, 32'h0, 32'hFFFF_FFF9, 32'd2, 32'h0);
    check("div_off_valid", 64'(bus.out_valid), 64'd1);
    check("div_off_alu", 64'(bus.aluResult_out), 64'd0);
    check("div_off_busy", 64'(bus.busy), 64'd0);
    issue(cbit(12), 32'h0, 32'h0, 32'd9, 32'd4, 32'h0);
    check("mod_off_alu", 64'(bus.aluResult_out), 64'd0);
    check("mod_off_in_ready", 64'(bus.in_ready), 64'd1);
`endif

    // Reset in the middle of activity
    issue(cbit(9), 32'h0, 32'h0, 32'd5, 32'd3, 32'h0);
`ifdef SIMPLERISC_DIV_EN
    issue(cbit(11), 32'h0, 32'h0, 32'd100, 32'd7, 32'h0);
    repeat (5) begin @(posedge clk); #1; end
    check("mid_div_busy", 64'(bus.busy), 64'd1);
`else
    bus.out_ready = 1'b0;
    issue(cbit(7), 32'h0, 32'h0, 32'd1, 32'd1, 32'h0);
    check("mid_hold_valid", 64'(bus.out_valid), 64'd1);
`endif
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_flags", 64'(bus.flags_out), 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    issue(cbit(7), 32'h0, 32'h0, 32'd2, 32'd3, 32'h0);
    check("post_rst_add", 64'(bus.aluResult_out), 64'd5);
    check("post_rst_valid", 64'(bus.out_valid), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
